// File: rtl/norm_shift.sv
// Post-add normalizer for the binary16 ALU: renormalizes a 12-bit mantissa sum
// one shift per clock, then packs sign/exponent/fraction with ovf/unf flags.
module norm_shift (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        s_in,
    input  logic [4:0]  e_in,
    input  logic [11:0] m_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        ovf,
    output logic        unf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        s_q, s_d;
    logic [5:0]  e_q, e_d;
    logic [11:0] m_q, m_d;
    logic [15:0] res_q, res_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= 1'b0;
            e_q     <= 6'd0;
            m_q     <= 12'd0;
            res_q   <= 16'h0000;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            e_q     <= e_d;
            m_q     <= m_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // NORM takes exactly one action per cycle: a terminal pack or a single shift.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        e_d     = e_q;
        m_d     = m_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    s_d     = s_in;
                    e_d     = {1'b0, e_in};
                    m_d     = m_in;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = NORM;
                end
            end

            NORM: begin
                if (m_q == 12'd0) begin
                    res_d   = {s_q, 15'b0};
                    state_d = DONE;
                end else if (m_q[11]) begin
                    if (e_q >= 6'd30) begin
                        ovf_d   = 1'b1;
                        res_d   = {s_q, 5'h1F, 10'b0};
                        state_d = DONE;
                    end else begin
                        m_d = {1'b0, m_q[11:1]};
                        e_d = e_q + 6'd1;
                    end
                end else if (m_q[10]) begin
                    if (e_q >= 6'd31) begin
                        ovf_d = 1'b1;
                        res_d = {s_q, 5'h1F, 10'b0};
                    end else if (e_q == 6'd0) begin
                        unf_d = 1'b1;
                        res_d = {s_q, 15'b0};
                    end else begin
                        res_d = {s_q, e_q[4:0], m_q[9:0]};
                    end
                    state_d = DONE;
                end else begin
                    // Another left shift would push the exponent into the denormal range.
                    if (e_q <= 6'd1) begin
                        unf_d   = 1'b1;
                        res_d   = {s_q, 15'b0};
                        state_d = DONE;
                    end else begin
                        m_d = {m_q[10:0], 1'b0};
                        e_d = e_q - 6'd1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = res_q;
    assign ovf    = ovf_q;
    assign unf    = unf_q;

endmodule

// File: tb/tb_norm_shift.sv
// Self-checking bench for norm_shift: directed vectors, handshake and reset
// scenarios, then randomized operations against an arithmetic reference model.
module tb_norm_shift;

    logic        clk;
    logic        rst;
    logic        start;
    logic        s_in;
    logic [4:0]  e_in;
    logic [11:0] m_in;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        ovf;
    logic        unf;

    int errors = 0;
    int checks = 0;
    logic [15:0] prev_result;
    // Expected entry: {shift_count[5:0], ovf, unf, result[15:0]}
    logic [23:0] exp_q[$];

    norm_shift dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .s_in   (s_in),
        .e_in   (e_in),
        .m_in   (m_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovf    (ovf),
        .unf    (unf)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: locate the leading one and reason about the whole shift
    // distance at once, rather than stepping through cycles.
    function automatic logic [23:0] model(input logic s, input int e, input int m);
        logic [15:0] r;
        logic        o;
        logic        u;
        int          n;
        int          p;
        int          k;
        r = {s, 15'b0};
        o = 1'b0;
        u = 1'b0;
        n = 0;
        p = -1;
        for (int i = 0; i < 12; i++)
            if (m >= (1 << i)) p = i;
        if (p < 0) begin
            n = 0;
        end else if (p == 11) begin
            if (e >= 30) begin
                o = 1'b1;
                r = {s, 5'h1F, 10'h000};
            end else begin
                n = 1;
                r = {s, 5'(e + 1), 10'(m / 2)};
            end
        end else if (p == 10) begin
            if (e >= 31) begin
                o = 1'b1;
                r = {s, 5'h1F, 10'h000};
            end else if (e == 0) begin
                u = 1'b1;
            end else begin
                r = {s, 5'(e), 10'(m)};
            end
        end else begin
            k = 10 - p;
            if (e >= k + 1) begin
                n = k;
                r = {s, 5'(e - k), 10'(m * (1 << k))};
            end else begin
                n = (e > 1) ? e - 1 : 0;
                u = 1'b1;
            end
        end
        return {6'(n), o, u, r};
    endfunction

    // Driver: present an operation in IDLE and confirm the accept.
    task automatic start_op(input logic s, input logic [4:0] e, input logic [11:0] m, input bit hold);
        @(negedge clk);
        s_in  = s;
        e_in  = e;
        m_in  = m;
        start = 1'b1;
        exp_q.push_back(model(s, int'(e), int'(m)));
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        s_in = 1'($urandom);
        e_in = 5'($urandom);
        m_in = 12'($urandom);
        check_eq("accept_busy", busy, 1);
        check_eq("accept_ovf_clr", ovf, 0);
        check_eq("accept_unf_clr", unf, 0);
        check_eq("accept_result_held", result, prev_result);
    endtask

    // Scoreboard: wait (bounded) for done and compare against the queued expectation.
    task automatic wait_done(input string tag, input bit glitch);
        logic [23:0] x;
        int cyc;
        int busy_cnt;
        bit seen;
        bit held;
        x        = exp_q.pop_front();
        cyc      = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        held     = 1'b1;
        while (!seen && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
            else if (result !== prev_result) held = 1'b0;
            if (glitch) begin
                start = (cyc == 1 || cyc == 2);
                s_in  = 1'($urandom);
                e_in  = 5'($urandom);
                m_in  = 12'($urandom);
            end
        end
        check_eq({tag, "_done_seen"}, seen, 1);
        check_eq({tag, "_latency"}, cyc + 1, int'(x[23:18]) + 2);
        check_eq({tag, "_busy_cycles"}, busy_cnt, cyc);
        check_eq({tag, "_result_held"}, held, 1);
        check_eq({tag, "_result"}, result, x[15:0]);
        check_eq({tag, "_ovf"}, ovf, x[17]);
        check_eq({tag, "_unf"}, unf, x[16]);
        prev_result = x[15:0];
        @(posedge clk);
        #1;
        check_eq({tag, "_done_pulse"}, done, 0);
        check_eq({tag, "_idle"}, busy, 0);
    endtask

    task automatic run_op(input string tag, input logic s, input logic [4:0] e, input logic [11:0] m);
        start_op(s, e, m, 1'b0);
        wait_done(tag, 1'b0);
    endtask

    initial begin
        start       = 1'b0;
        s_in        = 1'b0;
        e_in        = 5'd0;
        m_in        = 12'd0;
        prev_result = 16'h0000;
        apply_reset();
        #1;
        check_eq("reset_result", result, 16'h0000);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_ovf", ovf, 0);
        check_eq("reset_unf", unf, 0);

        // Directed vectors
        run_op("pass", 1'b0, 5'd15, 12'h400);
        check_eq("pass_const", result, 16'h3C00);
        run_op("carry", 1'b0, 5'd15, 12'h800);
        check_eq("carry_const", result, 16'h4000);
        run_op("carry_ovf", 1'b1, 5'd30, 12'hC00);
        check_eq("carry_ovf_const", result, 16'hFC00);
        run_op("deep", 1'b0, 5'd20, 12'h001);
        check_eq("deep_const", result, 16'h2800);
        run_op("unf", 1'b1, 5'd3, 12'h040);
        check_eq("unf_const", {unf, result}, {1'b1, 16'h8000});
        run_op("zero", 1'b1, 5'd9, 12'h000);
        check_eq("zero_const", {unf, result}, {1'b0, 16'h8000});
        run_op("e31_ovf", 1'b0, 5'd31, 12'h5A5);
        run_op("e0_unf", 1'b0, 5'd0, 12'h7FF);
        run_op("carry_to_30", 1'b0, 5'd29, 12'hFFF);
        run_op("carry_from_0", 1'b1, 5'd0, 12'h801);
        run_op("e1_left", 1'b0, 5'd1, 12'h200);
        run_op("e2_left", 1'b0, 5'd2, 12'h200);

        // Extra start pulses during a long operation are ignored
        start_op(1'b1, 5'd20, 12'h001, 1'b0);
        wait_done("glitch", 1'b1);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq("glitch_no_second_done", {busy, done}, 2'b00);
        end

        // Back-to-back with start held high
        start_op(1'b0, 5'd15, 12'h800, 1'b1);
        s_in = 1'b1;
        e_in = 5'd10;
        m_in = 12'h0F0;
        wait_done("b2b_first", 1'b0);
        exp_q.push_back(model(1'b1, 10, 12'h0F0));
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("b2b_accept_next", busy, 1);
        check_eq("b2b_result_held", result, prev_result);
        wait_done("b2b_second", 1'b0);

        // Reset during NORM aborts without a done pulse
        start_op(1'b0, 5'd20, 12'h001, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_outputs", {busy, done, ovf, unf, result}, 20'h00000);
        void'(exp_q.pop_front());
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq("mid_rst_no_done", done, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        prev_result = 16'h0000;
        run_op("post_rst_pass", 1'b0, 5'd15, 12'h400);
        check_eq("post_rst_const", result, 16'h3C00);

        // Randomized operations
        for (int i = 0; i < 80; i++) begin
            logic        rs;
            logic [4:0]  re;
            logic [11:0] rm;
            rs = 1'($urandom);
            re = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0) rm = 12'h000;
            else rm = 12'($urandom_range(1, 4095) >> $urandom_range(0, 11));
            run_op("rand", rs, re, rm);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/norm_shift.md
# norm_shift

Post-add normalizer for the 16-bit half-precision ALU. It is the inverse stage of the exponent-compare and right-shift alignment step. It takes the raw sign, common exponent and 12-bit mantissa sum (carry bit plus hidden bit plus 10 fraction bits) and renormalizes iteratively, one shift per clock. It then packs an IEEE-754 binary16 result with overflow and underflow flags, and handshakes with the ALU controller through start/done.

## Interface

Parameters: none (format fixed at binary16: 1 sign, 5 exponent, 10 fraction bits).

Ports:
- clk  in  1  — single clock, rising edge.
- rst  in  1  — reset; asynchronous, active-high.
- start  in  1  — request. Sampled only in IDLE.
- s_in  in  1  — sign of the sum.
- e_in  in  5  — common (larger) exponent from the alignment stage.
- m_in  in  12  — mantissa sum; bit 11 is carry, bit 10 is the hidden-1 position.
- busy  out  1  — high while state is not IDLE.
- done  out  1  — one-cycle pulse when `result` and the flags are valid.
- result  out  16  — packed binary16 value {s, e[4:0], m[9:0]}.
- ovf  out  1  — result saturated to ±infinity.
- unf  out  1  — result flushed to ±zero because of exponent underflow.

## Operation

States: IDLE, NORM, DONE.

Internal registers:
- s: 1 bit.
- e: 6 bits, zero-extended on load.
- m: 12 bits.

IDLE:
- busy = 0.
- When start = 1, load s, e and m from the inputs, clear ovf and unf, and go to NORM.

NORM performs exactly one action per cycle. Priority, first match wins:
1. m == 0: result = {s, 15'b0}; go to DONE. This is an exact zero, not an underflow.
2. m[11] == 1:
   - If e >= 30: ovf = 1, result = {s, 5'h1F, 10'b0}; go to DONE.
   - Else: m = m >> 1 (bit 0 is truncated), e = e + 1; stay in NORM.
3. m[10] == 1:
   - If e >= 31: ovf = 1, result = {s, 5'h1F, 10'b0}.
   - Else if e == 0: unf = 1, result = {s, 15'b0}.
   - Else: result = {s, e[4:0], m[9:0]}.
   - In all three cases, go to DONE.
4. m[11:10] == 00:
   - If e <= 1: unf = 1, result = {s, 15'b0}; go to DONE.
   - Else: m = m << 1, e = e - 1; stay in NORM.

DONE: done = 1 for this cycle only; go to IDLE unconditionally.

Rules that apply in every state:
- No rounding: truncate only. Denormals are never produced; they are flushed to zero.
- result, ovf and unf hold their values from DONE until the next accepted start.
- start asserted while busy = 1 (NORM or DONE) is ignored. It is not queued.
- Input changes while busy have no effect, because the inputs are latched at accept.

## Timing

- Reset (asynchronous): state = IDLE. result = 16'h0000, done = 0, busy = 0, ovf = 0, unf = 0.
  - Reset mid-operation aborts the operation with no done pulse.
  - The first start after reset deasserts is accepted normally.
- Accept edge is T0, meaning start is sampled high in IDLE. Then:
  - busy = 1 from T0+1.
  - done = 1 in cycle T0+1+N+1, where N is the number of shift cycles spent in NORM (left or right).
  - busy drops when done drops, at return to IDLE.
- Latency examples:
  - Already normalized input: N = 0, so done is 2 cycles after accept.
  - Carry input: N = 1, so done is 3 cycles after accept.
  - Worst case, m = 12'h001: N = 10, so done is 12 cycles after accept.
- start may be held high continuously. A new operation is accepted in the IDLE cycle that follows each done.

## Test plan

- Normalized passthrough: s=0, e=15, m=12'h400 → result 16'h3C00, ovf=0, unf=0, done 2 cycles after accept.
- Carry renormalize: s=0, e=15, m=12'h800 → result 16'h4000, done 3 cycles after accept. Then e=30, m=12'hC00, s=1 → result 16'hFC00, ovf=1.
- Deep left shift: s=0, e=20, m=12'h001 → result 16'h2800 (e=10, fraction 0), done 12 cycles after accept, busy high for 12 cycles.
- Underflow flush: s=1, e=3, m=12'h040 → two shifts, then e == 1 with m[10] == 0 → result 16'h8000, unf=1. Exact zero: s=1, m=0 → 16'h8000 with unf=0.
- Handshake: pulse start again at accept+1 and accept+2 during a long operation → ignored, exactly one done, result unchanged until the next IDLE accept. Back-to-back with start held high → the second operation is accepted the cycle after done.
- Reset mid-operation: assert rst during NORM of the e=20, m=12'h001 case → all outputs 0 immediately, no done pulse. A subsequent passthrough vector yields 16'h3C00.
